ir_tx_scheduler: RTL and testbench

Shares the single Samsung IR transmitter (`samsung_protocol`) between several command requesters using round-robin arbitration. It issues each granted command as a one-cycle non-zero pulse on the transmitter's `command_in`. It then holds the link for a fixed frame time plus an inter-frame gap so that frames never overlap. It sits between the button/UART command sources and the transmitter.

---
 rtl/ir_pkg.sv | 26 ++
 rtl/ir_rr_arbiter.sv | 34 +++
 rtl/ir_tx_scheduler.sv | 122 ++++++++++++
 tb/tb_ir_tx_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared types and Samsung IR timing constants for the IR transmit path.
// Worst-case frame length is derived from the all-ones command.
package ir_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StFrame,
      StGap
   } ir_sched_state_t;

   localparam int unsigned LEADUP   = 225000;
   localparam int unsigned LEADDOWN = 225000;
   localparam int unsigned DATAUP   = 28000;
   localparam int unsigned DATA0    = 28000;
   localparam int unsigned DATA1    = 84500;
   localparam int unsigned STOP     = 28000;

   function automatic int unsigned ir_bit_cycles(input logic b);
      return DATAUP + (b ? DATA1 : DATA0);
   endfunction

   // Lower bound for the scheduler's FRAME_CYCLES in a real build.
   localparam int unsigned IR_FRAME_MAX_CYCLES =
      LEADUP + LEADDOWN + 32 * ir_bit_cycles(1'b1) + STOP;

endpackage

// File: rtl/ir_rr_arbiter.sv
// Combinational round-robin pick: the search starts just after the last granted index.
module ir_rr_arbiter
   import ir_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] winner,
   output logic [IDX_W-1:0]   winner_idx
);

   always_comb begin
      logic               found;
      int unsigned        idx;
      logic [NUM_REQ-1:0] sel;
      winner     = '0;
      winner_idx = '0;
      found      = 1'b0;
      idx        = 0;
      sel        = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last) + k) % NUM_REQ;
         sel = NUM_REQ'(1) << idx;
         if (!found && ((req & sel) != '0)) begin
            found      = 1'b1;
            winner     = sel;
            winner_idx = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/ir_tx_scheduler.sv
// Round-robin scheduler feeding one Samsung IR transmitter; holds the link for frame + gap.
// Define IR_SCHED_STATS_EN to add saturating frames_sent / frames_dropped counters.
module ir_tx_scheduler
   import ir_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 4,
   // Must be >= IR_FRAME_MAX_CYCLES on hardware; short values only shrink simulations.
   parameter int unsigned FRAME_CYCLES = 4_200_000,
   parameter int unsigned GAP_CYCLES   = 2_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*32-1:0] req_cmd,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [31:0]           cmd_out,
   output logic                  busy,
   output logic                  drop
`ifdef IR_SCHED_STATS_EN
   ,
   output logic [15:0]           frames_sent,
   output logic [15:0]           frames_dropped
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   ir_sched_state_t    state_q;
   logic [31:0]        counter_q;
   logic [IDX_W-1:0]   last_q;
   logic [NUM_REQ-1:0] winner;
   logic [IDX_W-1:0]   winner_idx;
   logic [31:0]        win_cmd;
   logic               arb_valid;
   logic               launch;
   logic               discard;

   ir_rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .req       (req),
      .last      (last_q),
      .winner    (winner),
      .winner_idx(winner_idx)
   );

   always_comb begin
      win_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner[i]) win_cmd = req_cmd[32*i +: 32];
      end
   end

   assign arb_valid = (state_q == StIdle) && (req != '0);
   assign launch    = arb_valid && (win_cmd != '0);
   assign discard   = arb_valid && (win_cmd == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         counter_q <= '0;
         last_q    <= IDX_W'(NUM_REQ - 1);
         gnt       <= '0;
         cmd_out   <= '0;
         busy      <= 1'b0;
         drop      <= 1'b0;
      end else begin
         gnt     <= '0;
         cmd_out <= '0;
         drop    <= 1'b0;
         case (state_q)
            StIdle: begin
               if (arb_valid) begin
                  gnt    <= winner;
                  last_q <= winner_idx;
               end
               if (launch) begin
                  cmd_out   <= win_cmd;
                  counter_q <= 32'd1;
                  state_q   <= StFrame;
                  busy      <= 1'b1;
               end
               if (discard) drop <= 1'b1;
            end
            StFrame: begin
               if (counter_q >= FRAME_CYCLES) begin
                  counter_q <= 32'd1;
                  state_q   <= StGap;
               end else begin
                  counter_q <= counter_q + 32'd1;
               end
            end
            StGap: begin
               if (counter_q >= GAP_CYCLES) begin
                  counter_q <= '0;
                  state_q   <= StIdle;
                  busy      <= 1'b0;
               end else begin
                  counter_q <= counter_q + 32'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef IR_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frames_sent    <= '0;
         frames_dropped <= '0;
      end else begin
         if (launch && frames_sent != 16'hFFFF) frames_sent <= frames_sent + 16'd1;
         if (discard && frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Directed bench for ir_tx_scheduler with NUM_REQ=4, FRAME_CYCLES=20, GAP_CYCLES=5.
module tb_ir_tx_scheduler;

   localparam int unsigned NUM_REQ      = 4;
   localparam int unsigned FRAME_CYCLES = 20;
   localparam int unsigned GAP_CYCLES   = 5;
   localparam int unsigned BUSY_LEN     = FRAME_CYCLES + GAP_CYCLES;      // 25
   localparam int unsigned PULSE_GAP    = FRAME_CYCLES + GAP_CYCLES + 1;  // 26

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NUM_REQ-1:0]    req = '0;
   logic [NUM_REQ*32-1:0] req_cmd = '0;
   logic [NUM_REQ-1:0]    gnt;
   logic [31:0]           cmd_out;
   logic                  busy;
   logic                  drop;
`ifdef IR_SCHED_STATS_EN
   logic [15:0]           frames_sent;
   logic [15:0]           frames_dropped;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ir_tx_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .FRAME_CYCLES(FRAME_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .req_cmd(req_cmd),
      .gnt    (gnt),
      .cmd_out(cmd_out),
      .busy   (busy),
      .drop   (drop)
`ifdef IR_SCHED_STATS_EN
      ,
      .frames_sent   (frames_sent),
      .frames_dropped(frames_dropped)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int i, input logic [31:0] c);
      req_cmd[32*i +: 32] = c;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b required 0000", gnt); end
      checks++;
      if (cmd_out !== 32'h0) begin errors++; $display("FAIL reset_cmd: got %h required 0", cmd_out); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++;
      if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b required 0", drop); end
      checks++;
      if (dut.last_q !== 2'd3) begin errors++; $display("FAIL reset_last: got %0d required 3", dut.last_q); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      int busy_cycles = 1;
      int stray = 0;
      int n = 0;
      set_cmd(2, 32'hE0E040BF);
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt: got %b required 0100", gnt); end
      checks++;
      if (cmd_out !== 32'hE0E040BF) begin
         errors++; $display("FAIL single_cmd: got %h required e0e040bf", cmd_out);
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b required 1", busy); end
      req = '0;
      while (busy && n < 60) begin
         tick();
         n++;
         if (busy) busy_cycles++;
         if (gnt !== 4'b0000 || cmd_out !== 32'h0) stray++;
      end
      checks++;
      if (busy_cycles != BUSY_LEN) begin
         errors++; $display("FAIL single_busy_len: got %0d required %0d", busy_cycles, BUSY_LEN);
      end
      checks++;
      if (stray != 0) begin errors++; $display("FAIL single_one_pulse: extra pulses %0d required 0", stray); end
   endtask

   task automatic test_request_during_frame();
      int n = 0;
      set_cmd(3, 32'h12345678);
      set_cmd(0, 32'hA5A50001);
      req = 4'b1000;
      tick();
      checks++;
      if (gnt !== 4'b1000 || cmd_out !== 32'h12345678) begin
         errors++; $display("FAIL frame_first: gnt %b cmd %h required 1000 12345678", gnt, cmd_out);
      end
      req = '0;
      repeat (3) begin
         tick();
         n++;
      end
      req[0] = 1'b1;
      do begin
         tick();
         n++;
      end while (gnt === 4'b0000 && n < 60);
      checks++;
      if (n != PULSE_GAP) begin errors++; $display("FAIL frame_wait: grant at %0d required %0d", n, PULSE_GAP); end
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL frame_gnt: got %b required 0001", gnt); end
      checks++;
      if (cmd_out !== 32'hA5A50001) begin errors++; $display("FAIL frame_cmd: got %h required a5a50001", cmd_out); end
      req = '0;
      wait_idle("frame");
   endtask

   task automatic test_zero_cmd();
      // last is 0 here, so requester 1 is searched before 3.
      set_cmd(1, 32'h0);
      set_cmd(3, 32'hE0E0D02F);
      req = 4'b1010;
      tick();
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL zero_gnt: got %b required 0010", gnt); end
      checks++;
      if (drop !== 1'b1) begin errors++; $display("FAIL zero_drop: got %b required 1", drop); end
      checks++;
      if (cmd_out !== 32'h0) begin errors++; $display("FAIL zero_cmd: got %h required 0", cmd_out); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
      req = 4'b1000;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("FAIL zero_next_gnt: got %b required 1000", gnt); end
      checks++;
      if (cmd_out !== 32'hE0E0D02F) begin errors++; $display("FAIL zero_next_cmd: got %h required e0e0d02f", cmd_out); end
      checks++;
      if (drop !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL zero_next_flags: drop %b busy %b required 0 1", drop, busy);
      end
      req = '0;
      wait_idle("zero");
   endtask

   task automatic test_back_to_back();
      logic [31:0] cmds [4];
      int          order [5];
      cmds  = '{32'h11110001, 32'h22220002, 32'h33330003, 32'h44440004};
      order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 4; i++) set_cmd(i, cmds[i]);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         int          n = 0;
         logic [3:0]  exp_gnt;
         exp_gnt = 4'b0001 << order[k];
         do begin
            tick();
            n++;
         end while (gnt === 4'b0000 && n < 60);
         if (k > 0) begin
            checks++;
            if (n != PULSE_GAP) begin
               errors++; $display("FAIL b2b_spacing%0d: got %0d required %0d", k, n, PULSE_GAP);
            end
         end
         checks++;
         if (gnt !== exp_gnt) begin errors++; $display("FAIL b2b_gnt%0d: got %b required %b", k, gnt, exp_gnt); end
         checks++;
         if (cmd_out !== cmds[order[k]]) begin
            errors++; $display("FAIL b2b_cmd%0d: got %h required %h", k, cmd_out, cmds[order[k]]);
         end
      end
      req = '0;
      wait_idle("b2b");
   endtask

   task automatic test_reset_mid_gap();
      set_cmd(1, 32'h0BADF00D);
      set_cmd(2, 32'hCAFE0002);
      set_cmd(3, 32'hBEEF0003);
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL rgap_first_gnt: got %b required 0100", gnt); end
      req = '0;
      repeat (FRAME_CYCLES + 2) tick();
      req = 4'b1010;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rgap_in_gap: busy %b required 1", busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rgap_busy: got %b required 0", busy); end
      checks++;
      if (cmd_out !== 32'h0 || gnt !== 4'b0000) begin
         errors++; $display("FAIL rgap_outputs: cmd %h gnt %b required 0 0000", cmd_out, gnt);
      end
      checks++;
      if (dut.last_q !== 2'd3) begin errors++; $display("FAIL rgap_last: got %0d required 3", dut.last_q); end
      tick();
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL rgap_gnt: got %b required 0010", gnt); end
      checks++;
      if (cmd_out !== 32'h0BADF00D) begin errors++; $display("FAIL rgap_cmd: got %h required 0badf00d", cmd_out); end
      req = '0;
      wait_idle("rgap");
   endtask

`ifdef IR_SCHED_STATS_EN
   task automatic test_stats();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      set_cmd(0, 32'h5A5A0000);
      set_cmd(1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         req = 4'b0001;
         tick();
         req = '0;
         wait_idle("stats_send");
      end
      for (int i = 0; i < 2; i++) begin
         req = 4'b0010;
         tick();
         req = '0;
         tick();
      end
      checks++;
      if (frames_sent !== 16'd3) begin errors++; $display("FAIL stats_sent: got %0d required 3", frames_sent); end
      checks++;
      if (frames_dropped !== 16'd2) begin
         errors++; $display("FAIL stats_dropped: got %0d required 2", frames_dropped);
      end
      force dut.frames_sent = 16'hFFFF;
      force dut.frames_dropped = 16'hFFFF;
      tick();
      release dut.frames_sent;
      release dut.frames_dropped;
      req = 4'b0010;
      tick();
      req = 4'b0001;
      tick();
      req = '0;
      wait_idle("stats_sat");
      checks++;
      if (frames_sent !== 16'hFFFF) begin errors++; $display("FAIL stats_sent_sat: got %h required ffff", frames_sent); end
      checks++;
      if (frames_dropped !== 16'hFFFF) begin
         errors++; $display("FAIL stats_drop_sat: got %h required ffff", frames_dropped);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_request_during_frame();
      test_zero_cmd();
      test_back_to_back();
      test_reset_mid_gap();
`ifdef IR_SCHED_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
